xor_oper_arb: RTL and testbench
===============================

Name: xor_oper_arb

Overview:
- Round-robin arbiter and scheduler that shares one xor_oper datapath instance among NUM_REQ requesters.
- Each requester submits an (a, b) operand pair over a valid/ready handshake. The block launches the pair into xor_oper, tracks it through the datapath latency, and buffers the result with the requester ID.
- Results are returned on one response channel with backpressure.
- Sits between requester logic and u_xor_oper; it owns the datapath's a and b inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 4, operand and result width; matches xor_oper.
- LAT, 1, register stages inside the datapath between a/b and co.
- FIFO_DEPTH, 4, response buffer entries (power of 2, >= LAT+1).

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_a  in  NUM_REQ*DW  packed operand a; requester i uses slice [i*DW +: DW].
- req_b  in  NUM_REQ*DW  packed operand b; same packing.
- dp_a  out  DW  operand a to xor_oper.
- dp_b  out  DW  operand b to xor_oper.
- dp_co  in  DW  result from xor_oper.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester index, where IDW = clog2(NUM_REQ).
- rsp_data  out  DW  XOR result.
- busy  out  1  high while any operation is in flight or buffered.

Behaviour:
- Reset (rstn low, asynchronous):
  - dp_a, dp_b, rsp_id, rsp_data = 0.
  - rsp_valid = 0, busy = 0, req_ready = 0.
  - RR pointer = NUM_REQ-1, so req0 has first priority.
  - In-flight pipeline and FIFO are cleared. Reset mid-operation discards all outstanding work; no stale response is ever presented after reset.
- Arbitration:
  - req_ready is combinational from req_valid, the RR pointer and the credit check. At most one bit is set per cycle.
  - Search order is ptr+1, ptr+2, ... wrapping modulo NUM_REQ.
  - On accept (req_valid[i] & req_ready[i] at edge E), the pointer becomes i.
  - A requester must hold valid and data stable until it is accepted. Ready may depend on valid.
- Credit:
  - outstanding = in-flight count + FIFO occupancy.
  - A grant is allowed only when outstanding < FIFO_DEPTH, so the FIFO never overflows.
  - At outstanding == FIFO_DEPTH, all req_ready are 0, even if a pop occurs that cycle.
- Launch:
  - At accept edge E, dp_a/dp_b register req_a/req_b slice i.
  - dp_a/dp_b hold their last value when idle.
  - Maximum throughput is one launch per cycle.
- Tracking:
  - A shift register of depth LAT+1 carries {valid, id}.
  - The stage-0 valid bit is set at E.
  - At edge E+LAT+1, dp_co and the id are written into the FIFO. With LAT=1, co is registered at E+1 and sampled at E+2.
- Response:
  - rsp_valid = FIFO not empty; rsp_id/rsp_data come from the FIFO head (registered FIFO storage).
  - A pop occurs at an edge with rsp_valid & rsp_ready.
  - A simultaneous push and pop leaves occupancy unchanged.
  - Responses are returned in launch order, which equals grant order.
  - rsp_ready low holds rsp_* stable.
- busy = (outstanding != 0), registered.
- Counters use IDW- and clog2(FIFO_DEPTH)+1-bit widths; wrap-around of pointers is modulo NUM_REQ or FIFO_DEPTH.

Decomposition:
- Package xor_arb_pkg holds:
  - NUM_REQ, DW, LAT and FIFO_DEPTH defaults.
  - A clog2 function.
  - An IDW constant.
  - A packed response struct/typedef {id, data}.
- One sub-module: xor_rsp_fifo, a synchronous FIFO of width IDW+DW and depth FIFO_DEPTH, with async active-low reset, push/pop/full/empty/count.
- The arbiter's round-robin search and the tracking pipeline stay in xor_oper_arb.

Test Plan:
1. Single request, req1 a=4'hF b=4'h9 after reset, rsp_ready=1 -> req_ready=4'b0010 in that cycle; dp_a=F, dp_b=9 after E; rsp_valid rises after E+2 with rsp_id=1, rsp_data=4'h6; popped next edge; busy returns to 0.
2. All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1... one per cycle; responses arrive in the same id order with correct XOR of distinct per-requester operands.
3. Backpressure, all requesting, rsp_ready=0 -> exactly 4 accepts, then req_ready=0 while the FIFO holds 4 entries; rsp_* stay stable. Raising rsp_ready gives one pop per cycle, and grants resume the cycle after outstanding < 4.
4. Fairness, pointer at 2, req2 (6,9) and req3 (8,9) valid together -> req3 granted first (data 4'h1), then req2 (data 4'hF).
5. Push/pop overlap at occupancy 3 with one in flight and rsp_ready=1 -> occupancy unchanged through the same-edge write and pop; no lost or duplicated entry.
6. Reset mid-operation: rstn low for 1 cycle with 3 outstanding -> rsp_valid and busy go 0 immediately (async). After release, no old response appears, and the first grant among req0..3 valid goes to req0.

Source files
------------

// File: rtl/xor_arb_pkg.sv
// Shared defaults, width helper and response record for the xor_oper arbiter slice.
package xor_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DW_DEF         = 4;
    localparam int LAT_DEF        = 1;
    localparam int FIFO_DEPTH_DEF = 4;

    // Ceiling log2, never below 1 so that index vectors stay legal.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int IDW = clog2(NUM_REQ_DEF);

    typedef struct packed {
        logic [IDW-1:0]    id;
        logic [DW_DEF-1:0] data;
    } rsp_t;

endpackage

// File: rtl/xor_rsp_fifo.sv
// Response buffer: synchronous FIFO with registered storage, head always visible on dout.
module xor_rsp_fifo
    import xor_arb_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/xor_oper_arb.sv
// Round-robin front end sharing one xor_oper datapath among NUM_REQ requesters,
// with credit-limited launch, latency tracking and an ordered response buffer.
module xor_oper_arb
    import xor_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DW         = DW_DEF,
    parameter int LAT        = LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int ID_W      = clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic [DW-1:0]         dp_a,
    output logic [DW-1:0]         dp_b,
    input  logic [DW-1:0]         dp_co,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic                  busy
);

    localparam int AW = clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;

    logic [ID_W-1:0] ptr;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0] gnt_id;
    logic accept;
    logic credit_ok;
    logic [DW-1:0] a_sl [NUM_REQ];
    logic [DW-1:0] b_sl [NUM_REQ];

    logic [LAT:0]    vld_p;
    logic [LAT:0]    vld_nxt;
    logic [ID_W-1:0] id_p [LAT+1];

    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [ID_W+DW-1:0] fifo_dout;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] out_nxt;

    function automatic logic [OW-1:0] popcnt(input logic [LAT:0] v);
        logic [OW-1:0] s;
        s = '0;
        for (int k = 0; k <= LAT; k++) s = s + OW'(v[k]);
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_sl[i] = req_a[i*DW +: DW];
            b_sl[i] = req_b[i*DW +: DW];
        end
    end

    // Credit counts work already in the datapath, so a same-cycle pop never opens a slot.
    assign outstanding = popcnt(vld_p) + OW'(fifo_cnt);
    assign credit_ok   = rstn && !fifo_full && (outstanding < OW'(FIFO_DEPTH));

    always_comb begin
        logic [ID_W-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        accept = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!accept && credit_ok && req_valid[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                accept   = 1'b1;
            end
        end
    end

    assign req_ready = gnt;

    assign push = vld_p[LAT];
    assign pop  = rsp_valid & rsp_ready;

    always_comb begin
        vld_nxt[0] = accept;
        for (int k = 1; k <= LAT; k++) vld_nxt[k] = vld_p[k-1];
    end

    assign out_nxt = popcnt(vld_nxt) + OW'(fifo_cnt) + OW'(push) - OW'(pop);

    // Stage 0: launch into the datapath; later stages follow it through LAT registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr   <= ID_W'(NUM_REQ - 1);
            dp_a  <= '0;
            dp_b  <= '0;
            vld_p <= '0;
            busy  <= 1'b0;
            for (int k = 0; k <= LAT; k++) id_p[k] <= '0;
        end else begin
            if (accept) begin
                ptr  <= gnt_id;
                dp_a <= a_sl[gnt_id];
                dp_b <= b_sl[gnt_id];
            end
            vld_p   <= vld_nxt;
            id_p[0] <= gnt_id;
            for (int k = 1; k <= LAT; k++) id_p[k] <= id_p[k-1];
            busy <= (out_nxt != '0);
        end
    end

    // Final stage: datapath result joins its id in the response buffer.
    xor_rsp_fifo #(
        .W     (ID_W + DW),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .din   ({id_p[LAT], dp_co}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign rsp_valid          = ~fifo_empty;
    assign {rsp_id, rsp_data} = fifo_dout;

endmodule

// File: tb/tb_xor_oper_arb.sv
// Directed bench for xor_oper_arb with a registered XOR datapath model and an ordered scoreboard.
module tb_xor_oper_arb;
    import xor_arb_pkg::*;

    localparam int N = NUM_REQ_DEF;
    localparam int W = DW_DEF;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [W-1:0]   dp_a;
    logic [W-1:0]   dp_b;
    logic [W-1:0]   dp_co;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;

    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    rsp_t exp_q [$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // One-register XOR datapath (LAT = 1).
    always @(posedge clk) dp_co <= dp_a ^ dp_b;

    xor_oper_arb dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_co     (dp_co),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic apply_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = opa[i];
            req_b[i*W +: W] = opb[i];
        end
    endtask

    task automatic set_ops(input logic [W-1:0] a0, b0, a1, b1, a2, b2, a3, b3);
        opa[0] = a0; opb[0] = b0; opa[1] = a1; opb[1] = b1;
        opa[2] = a2; opb[2] = b2; opa[3] = a3; opb[3] = b3;
        apply_ops();
    endtask

    // Advance one cycle; any response handshake seen at the negedge is scored.
    task automatic tick();
        rsp_t e;
        @(negedge clk);
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_extra", rsp_valid, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input int id);
        rsp_t e;
        chk($sformatf("req_ready_g%0d", id), req_ready, 32'd1 << id);
        e.id   = IDW'(id);
        e.data = opa[id] ^ opb[id];
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        chk("drain_done", (exp_q.size() == 0 && !busy), 32'd1);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        req_valid = '0;
        exp_q.delete();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = '1;
        rsp_ready = 1'b0;
        set_ops(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
        chk("rst_req_ready", req_ready, 32'd0);
        chk("rst_dp_a", dp_a, 32'd0);
        chk("rst_dp_b", dp_b, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rsp_id", rsp_id, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        req_valid = '0;
        rstn      = 1'b1;
        tick();

        // Single request from req1.
        rsp_ready = 1'b1;
        set_ops(4'h0, 4'h0, 4'hF, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0);
        req_valid = 4'b0010;
        #1;
        expect_grant(1);
        tick();
        req_valid = '0;
        #1;
        chk("t1_dp_a", dp_a, 32'hF);
        chk("t1_dp_b", dp_b, 32'h9);
        chk("t1_busy_hi", busy, 32'd1);
        chk("t1_rsp_early", rsp_valid, 32'd0);
        tick();
        chk("t1_rsp_e1", rsp_valid, 32'd0);
        tick();
        chk("t1_rsp_valid", rsp_valid, 32'd1);
        chk("t1_rsp_id", rsp_id, 32'd1);
        chk("t1_rsp_data", rsp_data, 32'h6);
        tick();
        chk("t1_rsp_gone", rsp_valid, 32'd0);
        chk("t1_busy_lo", busy, 32'd0);

        // All requesting, full throughput round robin.
        do_reset();
        rsp_ready = 1'b1;
        set_ops(4'h3, 4'h6, 4'h5, 4'h9, 4'hA, 4'h1, 4'hC, 4'h7);
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            #1;
            expect_grant(n % N);
            tick();
        end
        req_valid = '0;
        drain();

        // Backpressure fills the buffer, then release.
        do_reset();
        rsp_ready = 1'b0;
        set_ops(4'h1, 4'h2, 4'h4, 4'h8, 4'h7, 4'h7, 4'hE, 4'h3);
        req_valid = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            #1;
            expect_grant(n);
            tick();
        end
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("t3_hold_ready", req_ready, 32'd0);
            tick();
        end
        for (int n = 0; n < 2; n++) begin
            chk("t3_stable_valid", rsp_valid, 32'd1);
            chk("t3_stable_id", rsp_id, 32'd0);
            chk("t3_stable_data", rsp_data, opa[0] ^ opb[0]);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_ready_at_pop", req_ready, 32'd0);
        tick();
        for (int n = 0; n < 4; n++) begin
            #1;
            expect_grant(n);
            tick();
        end
        req_valid = '0;
        drain();

        // Fairness with the pointer parked at 2.
        do_reset();
        rsp_ready = 1'b1;
        set_ops(4'h0, 4'h0, 4'h0, 4'h0, 4'h6, 4'h9, 4'h8, 4'h9);
        req_valid = 4'b0100;
        #1;
        expect_grant(2);
        tick();
        req_valid = 4'b1100;
        #1;
        expect_grant(3);
        tick();
        req_valid = 4'b0100;
        #1;
        expect_grant(2);
        tick();
        req_valid = '0;
        drain();

        // Same-edge push and pop at occupancy 3.
        do_reset();
        rsp_ready = 1'b0;
        set_ops(4'h9, 4'h3, 4'hB, 4'h4, 4'h2, 4'hD, 4'h5, 4'h5);
        req_valid = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            #1;
            expect_grant(n);
            tick();
        end
        #1;
        chk("t5_full_ready", req_ready, 32'd0);
        tick();
        rsp_ready = 1'b1;
        #1;
        chk("t5_pop_ready", req_ready, 32'd0);
        chk("t5_head_id0", rsp_id, 32'd0);
        tick();
        #1;
        chk("t5_valid_after", rsp_valid, 32'd1);
        chk("t5_head_id1", rsp_id, 32'd1);
        expect_grant(0);
        tick();
        req_valid = '0;
        drain();

        // Reset with three operations outstanding.
        do_reset();
        rsp_ready = 1'b0;
        set_ops(4'h1, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h0, 4'h0);
        req_valid = 4'b0111;
        for (int n = 0; n < 3; n++) begin
            #1;
            expect_grant(n);
            tick();
        end
        req_valid = 4'b1111;
        rstn      = 1'b0;
        #1;
        chk("t6_rsp_valid_async", rsp_valid, 32'd0);
        chk("t6_busy_async", busy, 32'd0);
        chk("t6_ready_in_rst", req_ready, 32'd0);
        chk("t6_dp_a_rst", dp_a, 32'd0);
        exp_q.delete();
        tick();
        rstn      = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk("t6_no_stale", rsp_valid, 32'd0);
            tick();
        end
        req_valid = 4'b1111;
        #1;
        expect_grant(0);
        tick();
        req_valid = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
